// File: rtl/core_pkg.sv
// Shared encodings for the memory stage: result-select values,
// load/store size codes and the load/store unit state type.
package core_pkg;

  localparam logic [1:0] ALU_RESULT = 2'b00;
  localparam logic [1:0] MEM_TO_REG = 2'b01;
  localparam logic [1:0] PC_PLUS    = 2'b10;
  localparam logic [1:0] LUI_AUIPC  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/stage_memory_lsu_align.sv
// Byte-lane steering for stores, alignment check, and load
// extraction/extension from a full bus word.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        store,
  input  logic [31:0] store_data,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Store byte enables / lane replication and natural-alignment check.
  always_comb begin
    be         = '1;
    wdata      = store_data;
    misaligned = 1'b0;
    if (store) begin
      case (funct3)
        F3_B: begin
          be    = 4'b0001 << offset;
          wdata = {4{store_data[7:0]}};
        end
        F3_H: begin
          be    = offset[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
    case (funct3)
      F3_H, F3_HU: misaligned = offset[0];
      F3_W:        misaligned = |offset;
      default:     misaligned = 1'b0;
    endcase
  end

  // Shift the addressed bytes down to bit 0 and extend per access size.
  always_comb begin
    shifted   = rdata >> {load_offset, 3'b000};
    load_data = '0;
    case (load_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'b0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'b0, shifted[15:0]};
      F3_W:    load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: runs loads/stores over a req/gnt/rvalid data bus,
// stalls upstream while a transaction is outstanding, and registers
// results toward writeback.
module stage_memory
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       execute_alu_result,
  input  logic [31:0]       execute_wr_datamem_data,
  input  logic              execute_datamem_wr_enable,
  input  logic [1:0]        execute_result_src,
  input  logic [2:0]        execute_funct3,
  input  logic [4:0]        execute_rd,
  input  logic              execute_regfile_wr_enable,
  input  logic [31:0]       execute_instr_addr_plus,
  output logic              mem_stall,
  output logic [4:0]        mem_rd,
  output logic              mem_regfile_wr_enable,
  output logic [1:0]        mem_result_src,
  output logic [31:0]       mem_alu_result,
  output logic [31:0]       mem_read_data,
  output logic [31:0]       mem_instr_addr_plus,
  output logic              mem_misaligned,
  output logic              mem_bus_fault,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [31:0]       dbus_rdata
);

  localparam logic [7:0] TO_LIM = 8'(ACK_TIMEOUT);

  lsu_state_t        state, state_next;
  logic [7:0]        cnt;
  logic [ADDR_W-3:0] lat_word;
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_f3;
  logic [1:0]        lat_off;

  logic              access, misaligned, mis_access, go;
  logic              timeout, complete, abort;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, load_data;

  lsu_align u_align (
    .funct3      (execute_funct3),
    .offset      (execute_alu_result[1:0]),
    .store       (execute_datamem_wr_enable),
    .store_data  (execute_wr_datamem_data),
    .load_funct3 (lat_f3),
    .load_offset (lat_off),
    .rdata       (dbus_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .misaligned  (misaligned),
    .load_data   (load_data)
  );

  assign access     = execute_datamem_wr_enable | (execute_result_src == MEM_TO_REG);
  assign mis_access = access & misaligned;
  assign go         = access & ~misaligned;
  assign timeout    = (state == WAIT) && (cnt == TO_LIM);
  assign complete   = ((state == REQ) & dbus_gnt & dbus_rvalid) |
                      ((state == WAIT) & dbus_rvalid);
  assign abort      = (state == WAIT) & ~dbus_rvalid & timeout;

  // A response arriving with the grant completes in REQ, so the stall is
  // released there too; otherwise execute would re-issue the same access.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = go;
      REQ:     mem_stall = ~(dbus_gnt & dbus_rvalid);
      WAIT:    mem_stall = ~dbus_rvalid & ~timeout;
      default: mem_stall = 1'b0;
    endcase
  end

  assign dbus_req   = (state == REQ);
  assign dbus_we    = lat_we;
  assign dbus_addr  = {lat_word, 2'b00};
  assign dbus_be    = lat_be;
  assign dbus_wdata = lat_wdata;

  // Next-state logic for the IDLE -> REQ -> WAIT -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = REQ;
      REQ:     if (dbus_gnt) state_next = dbus_rvalid ? IDLE : WAIT;
      WAIT:    if (dbus_rvalid || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and response-timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == REQ && dbus_gnt) cnt <= '0;
      else if (state == WAIT)       cnt <= cnt + 8'd1;
    end
  end

  // Capture the bus request when an aligned access is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_word  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      lat_off   <= '0;
    end else if (state == IDLE && go) begin
      lat_word  <= execute_alu_result[ADDR_W-1:2];
      lat_we    <= execute_datamem_wr_enable;
      lat_be    <= al_be;
      lat_wdata <= al_wdata;
      lat_f3    <= execute_funct3;
      lat_off   <= execute_alu_result[1:0];
    end
  end

  // Pipeline registers toward writeback: bubble, passthrough, abort or completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd                <= '0;
      mem_regfile_wr_enable <= 1'b0;
      mem_result_src        <= '0;
      mem_alu_result        <= '0;
      mem_read_data         <= '0;
      mem_instr_addr_plus   <= '0;
      mem_misaligned        <= 1'b0;
      mem_bus_fault         <= 1'b0;
    end else begin
      mem_misaligned <= 1'b0;
      mem_bus_fault  <= 1'b0;
      if (mem_stall) begin
        mem_rd                <= '0;
        mem_regfile_wr_enable <= 1'b0;
      end else if (state == IDLE) begin
        mem_rd                <= execute_rd;
        mem_regfile_wr_enable <= execute_regfile_wr_enable & ~mis_access;
        mem_result_src        <= execute_result_src;
        mem_alu_result        <= execute_alu_result;
        mem_instr_addr_plus   <= execute_instr_addr_plus;
        mem_misaligned        <= mis_access;
      end else if (abort) begin
        mem_rd                <= '0;
        mem_regfile_wr_enable <= 1'b0;
        mem_bus_fault         <= 1'b1;
      end else if (complete) begin
        mem_rd                <= execute_rd;
        mem_regfile_wr_enable <= execute_regfile_wr_enable & ~lat_we;
        mem_result_src        <= execute_result_src;
        mem_alu_result        <= execute_alu_result;
        mem_instr_addr_plus   <= execute_instr_addr_plus;
        if (!lat_we) mem_read_data <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed scenarios plus randomized accesses,
// with the bench acting as bus slave and predicting results from the
// access rules.
module tb_stage_memory;
  import core_pkg::*;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] execute_alu_result, execute_wr_datamem_data, execute_instr_addr_plus;
  logic        execute_datamem_wr_enable, execute_regfile_wr_enable;
  logic [1:0]  execute_result_src;
  logic [2:0]  execute_funct3;
  logic [4:0]  execute_rd;
  logic        mem_stall, mem_regfile_wr_enable, mem_misaligned, mem_bus_fault;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_read_data, mem_instr_addr_plus;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_pc, m_rdat;

  always #5 clk = ~clk;

  stage_memory #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .execute_alu_result(execute_alu_result),
    .execute_wr_datamem_data(execute_wr_datamem_data),
    .execute_datamem_wr_enable(execute_datamem_wr_enable),
    .execute_result_src(execute_result_src),
    .execute_funct3(execute_funct3),
    .execute_rd(execute_rd),
    .execute_regfile_wr_enable(execute_regfile_wr_enable),
    .execute_instr_addr_plus(execute_instr_addr_plus),
    .mem_stall(mem_stall), .mem_rd(mem_rd),
    .mem_regfile_wr_enable(mem_regfile_wr_enable),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_instr_addr_plus(mem_instr_addr_plus),
    .mem_misaligned(mem_misaligned), .mem_bus_fault(mem_bus_fault),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop(input logic [4:0] rd, input logic wen, input logic [31:0] alu,
                           input logic [31:0] pc);
    execute_alu_result        = alu;
    execute_wr_datamem_data   = '0;
    execute_datamem_wr_enable = 1'b0;
    execute_result_src        = ALU_RESULT;
    execute_funct3            = '0;
    execute_rd                = rd;
    execute_regfile_wr_enable = wen;
    execute_instr_addr_plus   = pc;
  endtask

  // One instruction through the stage; rdly < 0 means no response ever.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic wen, input logic [1:0] rs_alu,
                       input int gdly, input int rdly, input logic [31:0] rdata,
                       input logic [31:0] pc);
    bit access, mis, bus, tout, finished, granted, stable, saw_req, was_gnt;
    logic [1:0]  off, rs;
    logic [31:0] sh, e_load, e_be, e_wdata;
    logic [31:0] f_addr, f_wdata, c_addr, c_wdata;
    logic [3:0]  f_be, c_be;
    logic        c_we;
    int stalls, reqc, waitc, cyc, e_stalls;

    access = ld | st;
    off    = addr[1:0];
    mis    = access && ((((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
                        ((f3 == F3_W) && (off != 2'b00)));
    bus    = access && !mis;
    tout   = bus && (rdly < 0);
    rs     = ld ? MEM_TO_REG : rs_alu;

    execute_alu_result        = addr;
    execute_wr_datamem_data   = sdata;
    execute_datamem_wr_enable = st;
    execute_result_src        = rs;
    execute_funct3            = f3;
    execute_rd                = rd;
    execute_regfile_wr_enable = wen;
    execute_instr_addr_plus   = pc;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;

    stalls = 0; reqc = 0; waitc = 0; cyc = 0;
    finished = 0; granted = 0; stable = 1; saw_req = 0;
    f_addr = '0; f_wdata = '0; f_be = '0; c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    while (!finished && cyc < 1000) begin
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
      if (!granted && dbus_req) begin
        saw_req = 1;
        if (reqc == 0) begin
          f_addr = dbus_addr; f_be = dbus_be; f_wdata = dbus_wdata;
        end else if (dbus_addr !== f_addr || dbus_be !== f_be || dbus_wdata !== f_wdata) begin
          stable = 0;
        end
        if (reqc == gdly) begin
          dbus_gnt = 1'b1;
          c_addr = dbus_addr; c_be = dbus_be; c_wdata = dbus_wdata; c_we = dbus_we;
          if (rdly == 0) begin dbus_rvalid = 1'b1; dbus_rdata = rdata; end
        end
        reqc++;
      end else if (granted) begin
        waitc++;
        if (rdly > 0 && waitc == rdly) begin dbus_rvalid = 1'b1; dbus_rdata = rdata; end
      end
      #1;
      if (mem_stall) stalls++;
      else finished = 1;
      was_gnt = dbus_gnt;
      @(posedge clk); #1;
      if (was_gnt) granted = 1;
      cyc++;
      if (!finished) chk("bubble", {27'b0, mem_rd} | {31'b0, mem_regfile_wr_enable}, 32'd0);
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    if (!finished) chk("completion_timeout", 32'd0, 32'd1);

    if (!bus)            e_stalls = 0;
    else if (tout)       e_stalls = 2 + gdly + int'(TO);
    else if (rdly == 0)  e_stalls = 1 + gdly;
    else                 e_stalls = 1 + gdly + rdly;
    chk("stall_cycles", stalls, e_stalls);

    if (bus) begin
      e_be = 32'hF; e_wdata = sdata;
      if (st && f3 == F3_B) begin
        e_be = 32'd1 << off; e_wdata = sdata[7:0] * 32'h0101_0101;
      end else if (st && f3 == F3_H) begin
        e_be = off[1] ? 32'hC : 32'h3; e_wdata = sdata[15:0] * 32'h0001_0001;
      end
      chk("req_cycles", reqc, gdly + 1);
      chk("req_stable", {31'b0, stable}, 32'd1);
      chk("dbus_addr", c_addr, addr & ~32'h3);
      chk("dbus_we", {31'b0, c_we}, {31'b0, st});
      if (st) begin
        chk("dbus_be", {28'b0, c_be}, e_be);
        chk("dbus_wdata", c_wdata, e_wdata);
      end
    end else begin
      chk("no_req", {31'b0, saw_req}, 32'd0);
    end

    sh = rdata >> (8 * off);
    case (f3)
      F3_B:    e_load = 32'($signed(sh[7:0]));
      F3_BU:   e_load = 32'(sh[7:0]);
      F3_H:    e_load = 32'($signed(sh[15:0]));
      F3_HU:   e_load = 32'(sh[15:0]);
      F3_W:    e_load = sh;
      default: e_load = 32'd0;
    endcase

    if (tout) begin
      chk("mem_rd", {27'b0, mem_rd}, 32'd0);
      chk("mem_wen", {31'b0, mem_regfile_wr_enable}, 32'd0);
    end else begin
      m_rs = rs; m_alu = addr; m_pc = pc;
      if (bus && ld) m_rdat = e_load;
      chk("mem_rd", {27'b0, mem_rd}, {27'b0, rd});
      chk("mem_wen", {31'b0, mem_regfile_wr_enable}, {31'b0, wen && !st && !mis});
    end
    chk("mem_result_src", {30'b0, mem_result_src}, {30'b0, m_rs});
    chk("mem_alu_result", mem_alu_result, m_alu);
    chk("mem_pc_plus", mem_instr_addr_plus, m_pc);
    chk("mem_read_data", mem_read_data, m_rdat);
    chk("mem_misaligned", {31'b0, mem_misaligned}, {31'b0, mis});
    chk("mem_bus_fault", {31'b0, mem_bus_fault}, {31'b0, tout});

    if (mis || tout) begin
      drive_nop(5'd0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      m_rs = ALU_RESULT; m_alu = '0; m_pc = '0;
      chk("pulse_clear", {30'b0, mem_misaligned, mem_bus_fault}, 32'd0);
    end
  endtask

  initial begin : stim
    logic [2:0]  lf3 [6];
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic [31:0] a;
    int unsigned kind;
    int          rd_lat;

    lf3[0] = F3_B; lf3[1] = F3_H; lf3[2] = F3_W;
    lf3[3] = F3_BU; lf3[4] = F3_HU; lf3[5] = 3'b011;
    m_rs = '0; m_alu = '0; m_pc = '0; m_rdat = '0;

    rst_n = 1'b0;
    drive_nop(5'd0, 1'b0, 32'd0, 32'd0);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_req", {31'b0, dbus_req}, 32'd0);
    chk("rst_rd_wen", {26'b0, mem_rd, mem_regfile_wr_enable}, 32'd0);
    chk("rst_alu", mem_alu_result, 32'd0);
    chk("rst_rdata", mem_read_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU passthrough
    do_op(0, 0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1, ALU_RESULT, 0, 0, 32'd0, 32'h44);
    // LB at 0x103, sign-extended byte 0x80
    do_op(1, 0, F3_B, 32'h103, 32'd0, 5'd6, 1'b1, ALU_RESULT, 1, 1, 32'h80FF_0000, 32'h48);
    // SH at 0x202, upper-half lanes
    do_op(0, 1, F3_H, 32'h202, 32'h0000_BEEF, 5'd7, 1'b1, ALU_RESULT, 0, 2, 32'd0, 32'h4C);
    // misaligned LW
    do_op(1, 0, F3_W, 32'h006, 32'd0, 5'd8, 1'b1, ALU_RESULT, 0, 0, 32'd0, 32'h50);
    // LHU, late grant, no response -> timeout
    do_op(1, 0, F3_HU, 32'h010, 32'd0, 5'd9, 1'b1, ALU_RESULT, 4, -1, 32'd0, 32'h54);
    // response in the grant cycle
    do_op(1, 0, F3_W, 32'h020, 32'd0, 5'd10, 1'b1, ALU_RESULT, 2, 0, 32'hCAFE_F00D, 32'h58);
    // undefined load size yields zero
    do_op(1, 0, 3'b011, 32'h031, 32'd0, 5'd11, 1'b1, ALU_RESULT, 0, 1, 32'hFFFF_FFFF, 32'h5C);

    for (int unsigned i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom;
      rs   = 2'($urandom_range(0, 3));
      if (rs == MEM_TO_REG) rs = PC_PLUS;
      if (kind == 1) f3 = lf3[$urandom_range(0, 5)];
      else if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      rd_lat = int'($urandom_range(0, 3));
      do_op(kind == 1, kind == 2, f3, a, $urandom, 5'($urandom), 1'($urandom),
            (kind == 0) ? rs : ALU_RESULT, int'($urandom_range(0, 3)), rd_lat,
            $urandom, $urandom);
    end

    // reset while waiting for a response, then a stray response in IDLE
    execute_alu_result = 32'h40; execute_datamem_wr_enable = 1'b0;
    execute_result_src = MEM_TO_REG; execute_funct3 = F3_W;
    execute_rd = 5'd9; execute_regfile_wr_enable = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b1;
    @(posedge clk); #1;
    dbus_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_nop(5'd0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("rst2_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst2_req", {31'b0, dbus_req}, 32'd0);
    chk("rst2_rd_wen", {26'b0, mem_rd, mem_regfile_wr_enable}, 32'd0);
    chk("rst2_bus", {dbus_addr[27:0], dbus_be} | dbus_wdata | {31'b0, dbus_we}, 32'd0);
    chk("rst2_outs", mem_alu_result | mem_read_data | mem_instr_addr_plus, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_rs = '0; m_alu = '0; m_pc = '0; m_rdat = '0;
    drive_nop(5'd7, 1'b1, 32'h55, 32'h99);
    dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("late_rvalid_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    m_alu = 32'h55; m_pc = 32'h99;
    chk("late_rvalid_rd", {27'b0, mem_rd}, 32'd7);
    chk("late_rvalid_data", mem_read_data, m_rdat);
    do_op(1, 0, F3_BU, 32'h081, 32'd0, 5'd12, 1'b1, ALU_RESULT, 1, 2, 32'h1234_A5C3, 32'h60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
